// File: rtl/lcd_spi_pkg.sv
// Shared constants and types for the ST7735 receive-side monitor.
package lcd_spi_pkg;

    // ST7735 commands the decoder understands
    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    // Default panel geometry
    localparam int unsigned DEF_SCR_W = 128;
    localparam int unsigned DEF_SCR_H = 160;

    // Command decoder states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } dec_state_t;

endpackage

// File: rtl/lcd_spi_monitor_byte_rx.sv
// SPI mode-0 byte receiver: synchronises the asynchronous panel pins,
// shifts in MSB-first bytes and reports {dc, byte} words.
module spi_byte_rx
    import lcd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       dc,
    input  logic       sclk,
    input  logic       mosi,
    output logic [8:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    logic [1:0] cs_sync;
    logic [1:0] dc_sync;
    logic [1:0] sclk_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       sclk_rise;
    logic       cs_rise;

    // Edge detection on the synchronised pins
    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_prev;
        cs_rise   = cs_sync[1] & ~cs_prev;
    end

    // Synchronisers, bit capture, byte completion and framing-error detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // cs chain resets to the idle (deasserted) level so no false rise is seen
            cs_sync   <= '1;
            cs_prev   <= 1'b1;
            dc_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            shift     <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs};
            dc_sync   <= {dc_sync[0], dc};
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (sclk_rise && !cs_sync[1]) begin
                shift   <= {shift[6:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data  <= {dc_sync[1], shift[6:0], mosi_sync[1]};
                    rx_valid <= 1'b1;
                end
            end else if (cs_rise && bit_cnt != 3'd0) begin
                bit_cnt   <= '0;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_spi_monitor.sv
// ST7735 SPI monitor: rebuilds the {dc, byte} word stream from the panel
// pins and decodes CASET/RASET/RAMWR into a pixel stream.
module lcd_spi_monitor
    import lcd_spi_pkg::*;
#(
    parameter int unsigned SCR_W = DEF_SCR_W,
    parameter int unsigned SCR_H = DEF_SCR_H
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cs,
    input  logic        dc,
    input  logic        sclk,
    input  logic        mosi,
    output logic [8:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [15:0] pix_color,
    output logic        pix_valid
);

    localparam logic [8:0] XE_RST = 9'(SCR_W - 1);
    localparam logic [8:0] YE_RST = 9'(SCR_H - 1);

    dec_state_t state;
    logic [2:0] param_cnt;
    logic       param_hi;
    logic [7:0] color_hi;
    logic [8:0] xs, xe, ys, ye;
    logic [8:0] cur_x, cur_y;
    logic [7:0] rx_byte;
    logic       rx_is_data;

    spi_byte_rx u_rx (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .cs        (cs),
        .dc        (dc),
        .sclk      (sclk),
        .mosi      (mosi),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // Split the received word into its dc flag and payload
    always_comb begin
        rx_is_data = rx_data[8];
        rx_byte    = rx_data[7:0];
    end

    // Command decoder, window registers, cursor and pixel output
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            param_cnt <= '0;
            param_hi  <= 1'b0;
            color_hi  <= '0;
            xs        <= '0;
            xe        <= XE_RST;
            ys        <= '0;
            ye        <= YE_RST;
            cur_x     <= '0;
            cur_y     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_color <= '0;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            if (rx_valid) begin
                if (!rx_is_data) begin
                    // Any command aborts the current state, including a half pixel
                    param_cnt <= '0;
                    case (rx_byte)
                        CMD_CASET: state <= ST_CASET;
                        CMD_RASET: state <= ST_RASET;
                        CMD_RAMWR: begin
                            state <= ST_RAMWR_HI;
                            cur_x <= xs;
                            cur_y <= ys;
                        end
                        default:   state <= ST_IDLE;
                    endcase
                end else begin
                    case (state)
                        ST_CASET, ST_RASET: begin
                            if (param_cnt != 3'd4)
                                param_cnt <= param_cnt + 3'd1;
                            // Only bit 0 of a high byte survives the 9-bit truncation
                            case (param_cnt)
                                3'd0, 3'd2: param_hi <= rx_byte[0];
                                3'd1: begin
                                    if (state == ST_CASET) xs <= {param_hi, rx_byte};
                                    else                   ys <= {param_hi, rx_byte};
                                end
                                3'd3: begin
                                    if (state == ST_CASET) xe <= {param_hi, rx_byte};
                                    else                   ye <= {param_hi, rx_byte};
                                end
                                default: ;
                            endcase
                        end
                        ST_RAMWR_HI: begin
                            color_hi <= rx_byte;
                            state    <= ST_RAMWR_LO;
                        end
                        ST_RAMWR_LO: begin
                            pix_color <= {color_hi, rx_byte};
                            pix_x     <= cur_x;
                            pix_y     <= cur_y;
                            pix_valid <= 1'b1;
                            state     <= ST_RAMWR_HI;
                            // Equality-only compare: degenerate windows wrap mod 512
                            if (cur_x == xe) begin
                                cur_x <= xs;
                                cur_y <= (cur_y == ye) ? ys : cur_y + 9'd1;
                            end else begin
                                cur_x <= cur_x + 9'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
